// File: rtl/ped_request_scheduler_if.sv
// Button/request bundle between the pedestrian front-end and its user.
// master drives buttons and the controller's walk level; slave is the scheduler.
interface ped_request_scheduler_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn;
  logic             walk;
  logic             x;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] served;
  logic             busy;
  logic             fault;

  modport master (
    output btn, walk,
    input  x, pend, served, busy, fault
  );

  modport slave (
    input  btn, walk,
    output x, pend, served, busy, fault
  );
endinterface

// File: rtl/ped_request_scheduler.sv
// Merges crosswalk button presses into one registered request x, with a vehicle-green
// guard after each walk phase and a sticky fault if walk never answers. Press to x: 1 cycle.
module ped_request_scheduler #(
  parameter int N_BTN     = 4,
  parameter int MIN_GREEN = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  ped_request_scheduler_if.slave  bus
);

  localparam int GW = $clog2(MIN_GREEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_REQ   = 2'd2,
    S_WALK  = 2'd3
  } state_t;

  state_t           r_state;
  logic [N_BTN-1:0] r_btn_q;
  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] r_served;
  logic             r_x;
  logic             r_fault;
  logic [GW-1:0]    r_gcnt;
  logic [TW-1:0]    r_tcnt;

  state_t           w_state_nxt;
  logic [N_BTN-1:0] w_pend_nxt;
  logic [N_BTN-1:0] w_served_nxt;
  logic             w_x_nxt;
  logic             w_fault_nxt;
  logic [GW-1:0]    w_gcnt_nxt;
  logic [TW-1:0]    w_tcnt_nxt;
  logic [N_BTN-1:0] w_press;
  logic             w_req;

  assign w_press = bus.btn & ~r_btn_q;
  assign w_req   = (r_pend | w_press) != '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_GUARD;
      r_btn_q  <= '0;
      r_pend   <= '0;
      r_served <= '0;
      r_x      <= 1'b0;
      r_fault  <= 1'b0;
      r_gcnt   <= '0;
      r_tcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_btn_q  <= bus.btn;
      r_pend   <= w_pend_nxt;
      r_served <= w_served_nxt;
      r_x      <= w_x_nxt;
      r_fault  <= w_fault_nxt;
      r_gcnt   <= w_gcnt_nxt;
      r_tcnt   <= w_tcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    // A press while the crossing is already open is dropped, not queued.
    w_pend_nxt   = bus.walk ? r_pend : (r_pend | w_press);
    w_served_nxt = '0;
    w_x_nxt      = r_x;
    w_fault_nxt  = r_fault;
    w_gcnt_nxt   = r_gcnt;
    w_tcnt_nxt   = r_tcnt;

    if (r_state != S_WALK && bus.walk) begin
      // Controller-initiated walks also count as serving whatever was pending.
      w_served_nxt = r_pend;
      w_pend_nxt   = '0;
      w_x_nxt      = 1'b0;
      w_tcnt_nxt   = '0;
      w_gcnt_nxt   = '0;
      w_state_nxt  = S_WALK;
    end else begin
      unique case (r_state)
        S_GUARD: begin
          if (r_gcnt == GW'(MIN_GREEN - 1)) begin
            w_gcnt_nxt = '0;
            if (w_req) begin
              w_state_nxt = S_REQ;
              w_x_nxt     = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_gcnt_nxt = r_gcnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (w_req) begin
            w_state_nxt = S_REQ;
            w_x_nxt     = 1'b1;
          end
        end
        S_REQ: begin
          w_x_nxt = 1'b1;
          if (r_tcnt == TW'(TIMEOUT - 1)) begin
            w_fault_nxt = 1'b1;
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
          end
        end
        S_WALK: begin
          w_x_nxt = 1'b0;
          if (!bus.walk) begin
            w_state_nxt = S_GUARD;
            w_gcnt_nxt  = '0;
          end
        end
        default: w_state_nxt = S_GUARD;
      endcase
    end
  end

  assign bus.x      = r_x;
  assign bus.pend   = r_pend;
  assign bus.served = r_served;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.fault  = r_fault;

endmodule
